// File: rtl/ysyx_22050019_lsu.sv
// ysyx_22050019_lsu: memory-access stage, ALU pass-through plus valid/ready load/store bus transaction
// Ports: clk, rst_n (sync, active-high); EX/MEM inputs (ex_valid_i, pc_i, inst_i, commite_i, reg_we_i,
// reg_waddr_i, alu_result_i, mem_ren_i, mem_wen_i, mem_funct3_i, store_data_i); bus request
// (req_valid_o, req_ready_i, req_addr_o, req_wen_o, req_wdata_o, req_wstrb_o) and response
// (resp_valid_i, resp_rdata_i); mem_wb_stall_o, misalign_o; writeback bundle to MEM/WB
// (pc_o, inst_o, commite_o, reg_we_wbu_o, reg_waddr_wbu_o, reg_wdata_wbu_o).
// Option: define YSYX_22050019_LSU_MISALIGN_CHK_EN to trap misaligned H/W/D accesses instead of issuing them.
module ysyx_22050019_lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  input  logic            commite_i,
  input  logic            reg_we_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            mem_ren_i,
  input  logic            mem_wen_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  output logic            req_wen_o,
  output logic [XLEN-1:0] req_wdata_o,
  output logic [7:0]      req_wstrb_o,
  input  logic            resp_valid_i,
  input  logic [XLEN-1:0] resp_rdata_i,
  output logic            mem_wb_stall_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o,
  output logic            commite_o,
  output logic            reg_we_wbu_o,
  output logic [4:0]      reg_waddr_wbu_o,
  output logic [XLEN-1:0] reg_wdata_wbu_o
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state, state_nxt;
  logic [XLEN-1:0] pc_q, addr_q, sdata_q, rdata_q, shifted, load_val;
  logic [31:0] inst_q;
  logic [4:0] waddr_q;
  logic [2:0] f3_q, off;
  logic [7:0] strb_base;
  logic commite_q, we_q, ren_q, wen_q, mis_q, start, mis, idle, busy, done;
  assign idle = state == IDLE;
  assign busy = state == REQ || state == WAIT;
  assign done = state == DONE;
  assign start = idle && ex_valid_i && (mem_ren_i || mem_wen_i);
`ifdef YSYX_22050019_LSU_MISALIGN_CHK_EN
  assign mis = mem_funct3_i[1:0] == 2'd1 ? alu_result_i[0] :
               mem_funct3_i[1:0] == 2'd2 ? |alu_result_i[1:0] :
               mem_funct3_i[1:0] == 2'd3 ? |alu_result_i[2:0] : 1'b0;
  assign misalign_o = done && mis_q;
`else
  assign mis = 1'b0;
  assign misalign_o = 1'b0;
`endif
  // A trapped misaligned access has nothing to put on the bus, so it jumps straight to DONE.
  assign state_nxt = idle ? (start ? (mis ? DONE : REQ) : IDLE) :
                     state == REQ ? (req_ready_i ? WAIT : REQ) :
                     state == WAIT ? (resp_valid_i ? DONE : WAIT) : IDLE;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      pc_q <= '0;
      inst_q <= '0;
      commite_q <= 1'b0;
      we_q <= 1'b0;
      waddr_q <= '0;
      addr_q <= '0;
      ren_q <= 1'b0;
      wen_q <= 1'b0;
      f3_q <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        pc_q <= pc_i;
        inst_q <= inst_i;
        commite_q <= commite_i;
        we_q <= reg_we_i;
        waddr_q <= reg_waddr_i;
        addr_q <= alu_result_i;
        ren_q <= mem_ren_i;
        wen_q <= mem_wen_i;
        f3_q <= mem_funct3_i;
        sdata_q <= store_data_i;
        mis_q <= mis;
      end
      if (state == WAIT && resp_valid_i) rdata_q <= resp_rdata_i;
    end
  end
  assign off = addr_q[2:0];
  assign strb_base = f3_q[1:0] == 2'd0 ? 8'h01 : f3_q[1:0] == 2'd1 ? 8'h03 :
                     f3_q[1:0] == 2'd2 ? 8'h0F : 8'hFF;
  // Request fields are zero outside REQ so the bus sees a quiet interface between transfers.
  assign req_valid_o = state == REQ;
  assign req_addr_o = req_valid_o ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign req_wen_o = req_valid_o && wen_q;
  assign req_wstrb_o = req_valid_o ? strb_base << off : 8'h00;
  assign req_wdata_o = req_valid_o ? sdata_q << {off, 3'b000} : '0;
  assign shifted = rdata_q >> {off, 3'b000};
  assign load_val = f3_q == 3'b000 ? {{(XLEN-8){shifted[7]}}, shifted[7:0]} :
                    f3_q == 3'b001 ? {{(XLEN-16){shifted[15]}}, shifted[15:0]} :
                    f3_q == 3'b010 ? {{(XLEN-32){shifted[31]}}, shifted[31:0]} :
                    f3_q == 3'b100 ? {{(XLEN-8){1'b0}}, shifted[7:0]} :
                    f3_q == 3'b101 ? {{(XLEN-16){1'b0}}, shifted[15:0]} :
                    f3_q == 3'b110 ? {{(XLEN-32){1'b0}}, shifted[31:0]} : shifted;
  assign mem_wb_stall_o = start || busy;
  // In IDLE the bundle follows the inputs; once a memory access is latched it follows the latched copy.
  assign pc_o = idle ? (ex_valid_i ? pc_i : '0) : pc_q;
  assign inst_o = idle ? (ex_valid_i ? inst_i : 32'h0) : inst_q;
  assign reg_waddr_wbu_o = idle ? (ex_valid_i ? reg_waddr_i : 5'h0) : waddr_q;
  assign reg_wdata_wbu_o = idle ? (ex_valid_i ? alu_result_i : '0) : (ren_q ? load_val : addr_q);
  assign commite_o = idle ? ex_valid_i && commite_i && !start : done && commite_q;
  assign reg_we_wbu_o = idle ? ex_valid_i && reg_we_i && !start : done && we_q && !mis_q;
endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// tb_ysyx_22050019_lsu: scoreboard bench for the memory-access stage
module tb_ysyx_22050019_lsu;
  logic clk = 1'b0, rst_n = 1'b1;
  logic ex_valid_i = 0, commite_i = 0, reg_we_i = 0, mem_ren_i = 0, mem_wen_i = 0;
  logic req_ready_i = 0, resp_valid_i = 0;
  logic [63:0] pc_i = 0, alu_result_i = 0, store_data_i = 0, resp_rdata_i = 0;
  logic [31:0] inst_i = 0;
  logic [4:0] reg_waddr_i = 0;
  logic [2:0] mem_funct3_i = 0;
  logic req_valid_o, req_wen_o, mem_wb_stall_o, misalign_o, commite_o, reg_we_wbu_o;
  logic [63:0] req_addr_o, req_wdata_o, pc_o, reg_wdata_wbu_o;
  logic [7:0] req_wstrb_o;
  logic [31:0] inst_o;
  logic [4:0] reg_waddr_wbu_o;
  typedef struct {
    logic [63:0] pc;
    logic [63:0] wdata;
    logic [4:0] waddr;
    logic we;
    logic mis;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;
  int n_chk = 0, n_fail = 0, n_commit = 0;
  logic [63:0] next_pc = 64'h8000_0000;
  logic mis_en;
  ysyx_22050019_lsu dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .commite_i(commite_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .alu_result_i(alu_result_i), .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
    .mem_funct3_i(mem_funct3_i), .store_data_i(store_data_i), .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i), .req_addr_o(req_addr_o), .req_wen_o(req_wen_o),
    .req_wdata_o(req_wdata_o), .req_wstrb_o(req_wstrb_o), .resp_valid_i(resp_valid_i),
    .resp_rdata_i(resp_rdata_i), .mem_wb_stall_o(mem_wb_stall_o), .misalign_o(misalign_o),
    .pc_o(pc_o), .inst_o(inst_o), .commite_o(commite_o), .reg_we_wbu_o(reg_we_wbu_o),
    .reg_waddr_wbu_o(reg_waddr_wbu_o), .reg_wdata_wbu_o(reg_wdata_wbu_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic any_out();
    return |{req_valid_o, req_addr_o, req_wen_o, req_wdata_o, req_wstrb_o, mem_wb_stall_o,
             misalign_o, pc_o, inst_o, commite_o, reg_we_wbu_o, reg_waddr_wbu_o, reg_wdata_wbu_o};
  endfunction
  always @(negedge clk) begin
    if (!rst_n && commite_o) begin
      n_commit++;
      if (sb.size() == 0) chk("sb_unexpected_commit", 1, 0);
      else begin
        e_m = sb.pop_front();
        chk("wb_pc", pc_o, e_m.pc);
        chk("wb_we", reg_we_wbu_o, e_m.we);
        chk("wb_misalign", misalign_o, e_m.mis);
        if (e_m.we) begin
          chk("wb_waddr", reg_waddr_wbu_o, e_m.waddr);
          chk("wb_wdata", reg_wdata_wbu_o, e_m.wdata);
        end
      end
    end
  end
  task automatic go_idle();
    @(posedge clk); #1;
    ex_valid_i = 0; mem_ren_i = 0; mem_wen_i = 0; commite_i = 0; reg_we_i = 0;
    req_ready_i = 0; resp_valid_i = 0;
  endtask
  task automatic alu_op(input logic [63:0] alu, input logic [4:0] wa);
    @(posedge clk); #1;
    ex_valid_i = 1; pc_i = next_pc; inst_i = 32'h0000_0033; commite_i = 1; reg_we_i = 1;
    reg_waddr_i = wa; alu_result_i = alu; mem_ren_i = 0; mem_wen_i = 0;
    sb.push_back('{next_pc, alu, wa, 1'b1, 1'b0});
    next_pc += 4;
    @(negedge clk);
    chk("alu_stall", mem_wb_stall_o, 0);
    chk("alu_wdata", reg_wdata_wbu_o, alu);
    chk("alu_waddr", reg_waddr_wbu_o, wa);
    go_idle();
  endtask
  task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] sd, input logic [63:0] rd, input int rdy_w,
                        input int rsp_w, input logic mis, input logic [7:0] e_strb,
                        input logic [63:0] e_wdata, input logic [63:0] e_res);
    int stalls, rw, sw, c0;
    logic hs, rsent, fin, seen_req;
    @(posedge clk); #1;
    ex_valid_i = 1; pc_i = next_pc; inst_i = next_pc[31:0] ^ 32'h3; commite_i = 1;
    reg_we_i = ld; reg_waddr_i = 5'd9; alu_result_i = addr; mem_ren_i = ld; mem_wen_i = !ld;
    mem_funct3_i = f3; store_data_i = sd; resp_rdata_i = rd;
    sb.push_back('{next_pc, e_res, 5'd9, ld && !mis, mis});
    next_pc += 4;
    c0 = n_commit;
    stalls = 0; rw = 0; sw = 0; hs = 0; rsent = 0; fin = 0; seen_req = 0;
    for (int g = 0; g < 60 && !fin; g++) begin
      @(negedge clk);
      if (mem_wb_stall_o) stalls++;
      else fin = 1;
      if (req_valid_o) begin
        seen_req = 1;
        chk("req_addr", req_addr_o, {addr[63:3], 3'b000});
        chk("req_wen", req_wen_o, !ld);
        chk("req_wstrb", req_wstrb_o, e_strb);
        chk("req_wdata", req_wdata_o, e_wdata);
      end
      if (!fin) begin
        @(posedge clk); #1;
        if (req_valid_o) begin
          req_ready_i = rw == rdy_w; hs = hs | req_ready_i; rw++; resp_valid_i = 0;
        end else if (hs && !rsent) begin
          resp_valid_i = sw == rsp_w; rsent = resp_valid_i; sw++; req_ready_i = 0;
        end else begin
          req_ready_i = 0; resp_valid_i = 0;
        end
      end
    end
    chk("done_timeout", fin, 1);
    chk("stall_cycles", stalls, mis ? 1 : 3 + rdy_w + rsp_w);
    chk("bus_req_seen", seen_req, !mis);
    go_idle();
    @(negedge clk);
    chk("commit_once", n_commit - c0, 1);
  endtask
  initial begin
    int c0;
`ifdef YSYX_22050019_LSU_MISALIGN_CHK_EN
    mis_en = 1;
`else
    mis_en = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("reset_outputs", any_out(), 0);
    alu_op(64'h1234, 5'd5);
    mem_op(1, 3'b000, 64'h8000_0003, 0, 64'h0000_0000_80FF_0000, 0, 0, 0, 8'h08, 0, 64'hFFFF_FFFF_FFFF_FF80);
    mem_op(0, 3'b001, 64'h8000_0006, 64'hABCD, 0, 0, 0, 0, 8'hC0, 64'hABCD_0000_0000_0000, 0);
    mem_op(1, 3'b011, 64'h8000_0010, 0, 64'h0123_4567_89AB_CDEF, 3, 2, 0, 8'hFF, 0, 64'h0123_4567_89AB_CDEF);
    mem_op(1, 3'b101, 64'h8000_000A, 0, 64'h0000_0000_8765_0000, 1, 0, 0, 8'h0C, 0, 64'h8765);
    mem_op(1, 3'b010, 64'h8000_0004, 0, 64'h8000_0001_0000_0000, 0, 1, 0, 8'hF0, 0, 64'hFFFF_FFFF_8000_0001);
    mem_op(0, 3'b010, 64'h8000_0004, 64'hDEAD_BEEF, 0, 2, 0, 0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 0);
    mem_op(0, 3'b000, 64'h8000_0001, 64'h1FF, 0, 0, 0, 0, 8'h02, 64'h1_FF00, 0);
    mem_op(1, 3'b110, 64'h8000_0000, 0, 64'hFFFF_FFFF_9000_0000, 0, 0, 0, 8'h0F, 0, 64'h9000_0000);
    alu_op(64'hFFFF_0000_0000_0001, 5'd31);
    if (mis_en) mem_op(1, 3'b010, 64'h8000_0002, 0, 64'h1122_3344_5566_7788, 0, 0, 1, 8'h00, 0, 0);
    else mem_op(1, 3'b010, 64'h8000_0002, 0, 64'h1122_3344_5566_7788, 0, 0, 0, 8'h3C, 0, 64'h3344_5566);
    c0 = n_commit;
    @(posedge clk); #1;
    ex_valid_i = 1; pc_i = next_pc; commite_i = 1; reg_we_i = 1; reg_waddr_i = 5'd3;
    alu_result_i = 64'h8000_0020; mem_ren_i = 1; mem_wen_i = 0; mem_funct3_i = 3'b011;
    @(posedge clk); #1;
    chk("rstw_req_valid", req_valid_o, 1);
    req_ready_i = 1;
    @(posedge clk); #1;
    chk("rstw_in_wait", {req_valid_o, mem_wb_stall_o}, 2'b01);
    req_ready_i = 0; rst_n = 1; ex_valid_i = 0; mem_ren_i = 0;
    @(posedge clk); #1;
    rst_n = 0; resp_valid_i = 1;
    @(negedge clk);
    chk("rstw_outputs", any_out(), 0);
    @(posedge clk); #1;
    resp_valid_i = 0;
    @(negedge clk);
    chk("rstw_outputs_after", any_out(), 0);
    repeat (3) @(negedge clk);
    chk("rstw_no_commit", n_commit - c0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
